// File: rtl/mdll_pkg.sv
// rtl/mdll_pkg.sv - shared types, mtune field bounds and window length helper for the MDLL lock detector
package mdll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } lockdet_state_t;

  localparam int MTUNE_MSB = 12;
  localparam int MTUNE_LSB = 6;
  localparam int MTUNE_W   = MTUNE_MSB - MTUNE_LSB + 1;

  // Window length in samples: 16/64/256/1024 for sel 0..3.
  function automatic logic [10:0] win_len(input logic [1:0] sel);
    case (sel)
      2'd0:    win_len = 11'd16;
      2'd1:    win_len = 11'd64;
      2'd2:    win_len = 11'd256;
      default: win_len = 11'd1024;
    endcase
  endfunction

endpackage

// File: rtl/mdll_minmax_track.sv
// rtl/mdll_minmax_track.sv - min/max tracking of mtune across a window, span includes the current sample
import mdll_pkg::*;

module mdll_minmax_track (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               upd_i,
  input  logic [MTUNE_W-1:0] sample_i,
  output logic [MTUNE_W-1:0] span_o
);

  logic [MTUNE_W-1:0] min_q, min_d;
  logic [MTUNE_W-1:0] max_q, max_d;

  // span_o reflects the window including this cycle's sample, so the window
  // end can register it without an extra pipeline stage.
  always_comb begin
    if (load_i) begin
      min_d = sample_i;
      max_d = sample_i;
    end else begin
      min_d = (sample_i < min_q) ? sample_i : min_q;
      max_d = (sample_i > max_q) ? sample_i : max_q;
    end
    span_o = max_d - min_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      min_q <= '0;
      max_q <= '0;
    end else if (clr_i) begin
      min_q <= '0;
      max_q <= '0;
    end else if (load_i || upd_i) begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

endmodule

// File: rtl/mdll_lock_detect.sv
// rtl/mdll_lock_detect.sv - windowed mtune excursion lock detector with unlock hysteresis and sticky loss flag
import mdll_pkg::*;

module mdll_lock_detect #(
  parameter int CNT_W = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [12:0]        lf_out_i,
  input  logic [1:0]         cfg_win_sel_i,
  input  logic [3:0]         cfg_tol_i,
  input  logic [3:0]         cfg_lock_n_i,
  input  logic               clear_sticky_i,
  output logic               locked_o,
  output logic               lock_lost_o,
  output logic               win_done_o,
  output logic [MTUNE_W-1:0] last_span_o,
  output logic [3:0]         good_cnt_o
);

  lockdet_state_t state_q, state_d;
  logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [3:0]         good_cnt_q, good_cnt_d;
  logic               locked_q, locked_d;
  logic               lock_lost_q, lock_lost_d;
  logic               win_done_q, win_done_d;
  logic [MTUNE_W-1:0] last_span_q, last_span_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         tol_q, tol_d;
  logic [3:0]         lock_n_q, lock_n_d;

  logic [MTUNE_W-1:0] mtune;
  logic [MTUNE_W-1:0] span;
  logic               active, win_start, win_end;
  logic [1:0]         sel_eff;
  logic [3:0]         tol_eff, lock_n_eff;
  logic [10:0]        len_m1;
  logic               good_win, bad_unlock;
  logic [4:0]         lock_need;
  logic               unused_dither;

  assign mtune         = lf_out_i[MTUNE_MSB:MTUNE_LSB];
  assign unused_dither = ^lf_out_i[MTUNE_LSB-1:0];

  assign active    = (state_q != ST_IDLE) && en_i;
  assign win_start = (win_cnt_q == '0);

  // Config is sampled at window start; the first cycle uses the live inputs.
  assign sel_eff    = win_start ? cfg_win_sel_i : sel_q;
  assign tol_eff    = win_start ? cfg_tol_i     : tol_q;
  assign lock_n_eff = win_start ? cfg_lock_n_i  : lock_n_q;

  assign len_m1     = win_len(sel_eff) - 11'd1;
  assign win_end    = (win_cnt_q == len_m1[CNT_W-1:0]);
  assign good_win   = ({3'b000, tol_eff} >= span);
  assign bad_unlock = ({1'b0, span} > {3'b000, tol_eff, 1'b0});
  assign lock_need  = (lock_n_eff == 4'd0) ? 5'd1 : {1'b0, lock_n_eff};

  mdll_minmax_track u_minmax (
    .clk_i    (clk_i),
    .rst_i    (reset_i),
    .clr_i    (!active),
    .load_i   (active && win_start),
    .upd_i    (active && !win_start),
    .sample_i (mtune),
    .span_o   (span)
  );

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    good_cnt_d  = good_cnt_q;
    locked_d    = locked_q;
    lock_lost_d = lock_lost_q;
    win_done_d  = 1'b0;
    last_span_d = last_span_q;
    sel_d       = sel_q;
    tol_d       = tol_q;
    lock_n_d    = lock_n_q;

    if (clear_sticky_i) lock_lost_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        win_cnt_d  = '0;
        good_cnt_d = 4'd0;
        locked_d   = 1'b0;
        if (en_i) state_d = ST_ACQ;
      end
      ST_ACQ, ST_LOCKED: begin
        if (!en_i) begin
          state_d    = ST_IDLE;
          win_cnt_d  = '0;
          good_cnt_d = 4'd0;
          locked_d   = 1'b0;
        end else begin
          if (win_start) begin
            sel_d    = cfg_win_sel_i;
            tol_d    = cfg_tol_i;
            lock_n_d = cfg_lock_n_i;
          end
          if (win_end) begin
            win_cnt_d   = '0;
            win_done_d  = 1'b1;
            last_span_d = span;
            if (good_win) begin
              good_cnt_d = (good_cnt_q == 4'hF) ? 4'hF : good_cnt_q + 4'd1;
              if (state_q == ST_ACQ && ({1'b0, good_cnt_q} + 5'd1 >= lock_need)) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              good_cnt_d = 4'd0;
            end
            // Loss of lock needs twice the lock tolerance; set beats clear.
            if (state_q == ST_LOCKED && bad_unlock) begin
              state_d     = ST_ACQ;
              locked_d    = 1'b0;
              good_cnt_d  = 4'd0;
              lock_lost_d = 1'b1;
            end
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      win_cnt_q   <= '0;
      good_cnt_q  <= 4'd0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      win_done_q  <= 1'b0;
      last_span_q <= '0;
      sel_q       <= 2'd0;
      tol_q       <= 4'd0;
      lock_n_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      good_cnt_q  <= good_cnt_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      win_done_q  <= win_done_d;
      last_span_q <= last_span_d;
      sel_q       <= sel_d;
      tol_q       <= tol_d;
      lock_n_q    <= lock_n_d;
    end
  end

  assign locked_o    = locked_q;
  assign lock_lost_o = lock_lost_q;
  assign win_done_o  = win_done_q;
  assign last_span_o = last_span_q;
  assign good_cnt_o  = good_cnt_q;

endmodule

// File: tb/tb_mdll_lock_detect.sv
// tb/tb_mdll_lock_detect.sv - directed self-checking bench for mdll_lock_detect
module tb_mdll_lock_detect;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [12:0] lf_out;
  logic [1:0]  cfg_win_sel;
  logic [3:0]  cfg_tol;
  logic [3:0]  cfg_lock_n;
  logic        clear_sticky;
  logic        locked;
  logic        lock_lost;
  logic        win_done;
  logic [6:0]  last_span;
  logic [3:0]  good_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mdll_lock_detect #(.CNT_W(10)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .en_i           (en),
    .lf_out_i       (lf_out),
    .cfg_win_sel_i  (cfg_win_sel),
    .cfg_tol_i      (cfg_tol),
    .cfg_lock_n_i   (cfg_lock_n),
    .clear_sticky_i (clear_sticky),
    .locked_o       (locked),
    .lock_lost_o    (lock_lost),
    .win_done_o     (win_done),
    .last_span_o    (last_span),
    .good_cnt_o     (good_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mt(input logic [6:0] mt);
    logic [5:0] d;
    d = 6'($urandom_range(63, 0));
    lf_out = {mt, d};
  endtask

  task automatic do_reset();
    en = 1'b0;
    clear_sticky = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; clear_sticky = 1'b0; lf_out = '0;
    cfg_win_sel = 2'd0; cfg_tol = 4'd0; cfg_lock_n = 4'd0;
    reset = 1'b1;
    #2;
    step();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0d expected 0", locked); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL reset_lock_lost: got %0d expected 0", lock_lost); end
    n_cmp++; if (win_done !== 1'b0) begin n_bad++; $display("FAIL reset_win_done: got %0d expected 0", win_done); end
    n_cmp++; if (last_span !== 7'd0) begin n_bad++; $display("FAIL reset_last_span: got %0d expected 0", last_span); end
    n_cmp++; if (good_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_good_cnt: got %0d expected 0", good_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_lock_basic();
    int wins;
    do_reset();
    cfg_win_sel = 2'd0; cfg_tol = 4'd1; cfg_lock_n = 4'd4;
    set_mt(7'h40);
    en = 1'b1;
    wins = 0;
    for (int k = 1; k <= 65; k++) begin
      set_mt(7'h40);
      step();
      if (win_done === 1'b1) wins++;
      if (k == 64) begin
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL basic_not_locked_64: got %0d expected 0", locked); end
      end
    end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL basic_locked_65: got %0d expected 1", locked); end
    n_cmp++; if (wins !== 4) begin n_bad++; $display("FAIL basic_win_count: got %0d expected 4", wins); end
    n_cmp++; if (last_span !== 7'd0) begin n_bad++; $display("FAIL basic_last_span: got %0d expected 0", last_span); end
    n_cmp++; if (good_cnt !== 4'd4) begin n_bad++; $display("FAIL basic_good_cnt: got %0d expected 4", good_cnt); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL basic_lock_lost: got %0d expected 0", lock_lost); end
  endtask

  // Continues from the locked state left by test_lock_basic.
  task automatic test_hysteresis_sticky();
    cfg_tol = 4'd2;
    for (int i = 0; i < 16; i++) begin
      set_mt(7'(7'h40 + (i % 5)));
      step();
    end
    n_cmp++; if (win_done !== 1'b1) begin n_bad++; $display("FAIL hyst_win_done: got %0d expected 1", win_done); end
    n_cmp++; if (last_span !== 7'd4) begin n_bad++; $display("FAIL hyst_span4: got %0d expected 4", last_span); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL hyst_lock_held: got %0d expected 1", locked); end
    n_cmp++; if (good_cnt !== 4'd0) begin n_bad++; $display("FAIL hyst_good_reset: got %0d expected 0", good_cnt); end
    for (int i = 0; i < 16; i++) begin
      set_mt(7'(7'h40 + (i % 6)));
      clear_sticky = (i == 15);
      step();
    end
    clear_sticky = 1'b0;
    n_cmp++; if (last_span !== 7'd5) begin n_bad++; $display("FAIL unlock_span5: got %0d expected 5", last_span); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL unlock_locked: got %0d expected 0", locked); end
    n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL unlock_set_wins: got %0d expected 1", lock_lost); end
    n_cmp++; if (good_cnt !== 4'd0) begin n_bad++; $display("FAIL unlock_good_cnt: got %0d expected 0", good_cnt); end
    set_mt(7'h40);
    step();
    n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL sticky_hold: got %0d expected 1", lock_lost); end
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL sticky_clear: got %0d expected 0", lock_lost); end
  endtask

  task automatic test_alternate();
    int pulses;
    logic ever_locked;
    do_reset();
    cfg_win_sel = 2'd0; cfg_tol = 4'd2; cfg_lock_n = 4'd4;
    en = 1'b1;
    step();
    pulses = 0;
    ever_locked = 1'b0;
    for (int k = 0; k < 80; k++) begin
      set_mt((k % 2) ? 7'h43 : 7'h40);
      step();
      if (locked === 1'b1) ever_locked = 1'b1;
      if (win_done === 1'b1) pulses++;
      if ((k % 16) == 15) begin
        n_cmp++; if (last_span !== 7'd3) begin n_bad++; $display("FAIL alt_span: got %0d expected 3", last_span); end
        n_cmp++; if (good_cnt !== 4'd0) begin n_bad++; $display("FAIL alt_good_cnt: got %0d expected 0", good_cnt); end
      end
    end
    n_cmp++; if (pulses !== 5) begin n_bad++; $display("FAIL alt_pulses: got %0d expected 5", pulses); end
    n_cmp++; if (ever_locked !== 1'b0) begin n_bad++; $display("FAIL alt_never_locked: got %0d expected 0", ever_locked); end
  endtask

  task automatic test_en_drop();
    int early;
    logic partial_done;
    do_reset();
    cfg_win_sel = 2'd0; cfg_tol = 4'd1; cfg_lock_n = 4'd4;
    en = 1'b1;
    step();
    partial_done = 1'b0;
    for (int k = 0; k < 7; k++) begin
      set_mt((k % 2) ? 7'h7F : 7'h00);
      step();
      if (win_done === 1'b1) partial_done = 1'b1;
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (win_done === 1'b1) partial_done = 1'b1;
    end
    n_cmp++; if (partial_done !== 1'b0) begin n_bad++; $display("FAIL endrop_partial: got %0d expected 0", partial_done); end
    en = 1'b1;
    step();
    early = 0;
    for (int k = 0; k < 16; k++) begin
      set_mt(7'h20);
      step();
      if (k < 15 && win_done === 1'b1) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL endrop_early_pulse: got %0d expected 0", early); end
    n_cmp++; if (win_done !== 1'b1) begin n_bad++; $display("FAIL endrop_win_done: got %0d expected 1", win_done); end
    n_cmp++; if (last_span !== 7'd0) begin n_bad++; $display("FAIL endrop_fresh_span: got %0d expected 0", last_span); end
    n_cmp++; if (good_cnt !== 4'd1) begin n_bad++; $display("FAIL endrop_good_cnt: got %0d expected 1", good_cnt); end
  endtask

  task automatic test_long_window_reset();
    do_reset();
    cfg_win_sel = 2'd3; cfg_tol = 4'd3; cfg_lock_n = 4'd0;
    en = 1'b1;
    step();
    for (int k = 0; k < 1024; k++) begin
      set_mt((k % 2) ? 7'h13 : 7'h11);
      step();
      if (k == 1022) begin
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL long_not_yet: got %0d expected 0", locked); end
      end
    end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL long_locked: got %0d expected 1", locked); end
    n_cmp++; if (last_span !== 7'd2) begin n_bad++; $display("FAIL long_span: got %0d expected 2", last_span); end
    n_cmp++; if (good_cnt !== 4'd1) begin n_bad++; $display("FAIL long_good_cnt: got %0d expected 1", good_cnt); end
    for (int k = 0; k < 500; k++) begin
      set_mt((k % 2) ? 7'h13 : 7'h11);
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL arst_locked: got %0d expected 0", locked); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL arst_lock_lost: got %0d expected 0", lock_lost); end
    n_cmp++; if (win_done !== 1'b0) begin n_bad++; $display("FAIL arst_win_done: got %0d expected 0", win_done); end
    n_cmp++; if (last_span !== 7'd0) begin n_bad++; $display("FAIL arst_last_span: got %0d expected 0", last_span); end
    n_cmp++; if (good_cnt !== 4'd0) begin n_bad++; $display("FAIL arst_good_cnt: got %0d expected 0", good_cnt); end
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_hysteresis_sticky();
    test_alternate();
    test_en_drop();
    test_long_window_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
